// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter and its return-address stack.
package pc_pkg;

   // Default sequential increment: word-addressed instruction memory.
   localparam int unsigned DEF_STEP     = 1;
   // Default fetch address after reset.
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   // Source of the next fetch address, listed from highest to lowest priority.
   typedef enum logic [2:0] {
      SEL_RESET,
      SEL_REDIRECT,
      SEL_HOLD,
      SEL_CALL,
      SEL_RET,
      SEL_SEQ
   } pc_sel_e;

   // Width of a counter able to hold the values 0..depth inclusive.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the oldest
// entry, so the most recent RAS_DEPTH return addresses are always retained.
// RAS_DEPTH must be a power of two so the pointer wraps naturally.
module ras_stack
   import pc_pkg::*;
#(
   parameter int unsigned PC_W      = 32,
   parameter int unsigned RAS_DEPTH = 8,
   localparam int unsigned PTR_W    = $clog2(RAS_DEPTH),
   localparam int unsigned CNT_W    = count_width(RAS_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [PC_W-1:0]  i_push_data,
   input  logic             i_pop,
   output logic [PC_W-1:0]  o_top,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_overflow,
   output logic             o_underflow
);

   logic [PC_W-1:0]  r_mem [RAS_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] w_top_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_full;
   logic             r_empty;
   logic             r_overflow;
   logic             w_do_pop;

   // A push takes precedence over a pop; a pop on an empty stack changes nothing.
   assign w_do_pop    = i_pop & ~i_push & ~r_empty;
   assign o_underflow = i_pop & ~i_push & r_empty;

   // r_wr_ptr is the next free slot, so the top of stack sits just below it.
   assign w_top_ptr = r_wr_ptr - PTR_W'(1);
   assign o_top     = r_mem[w_top_ptr];

   assign o_count    = r_count;
   assign o_full     = r_full;
   assign o_empty    = r_empty;
   assign o_overflow = r_overflow;

   // Next occupancy: saturates at RAS_DEPTH when a push overwrites the oldest entry.
   always_comb begin
      w_count_nxt = r_count;
      if (i_push) begin
         if (!r_full) begin
            w_count_nxt = r_count + CNT_W'(1);
         end
      end else if (w_do_pop) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   // Pointer, occupancy and registered status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (i_push) begin
            r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            r_overflow <= r_overflow | r_full;
         end else if (w_do_pop) begin
            r_wr_ptr <= w_top_ptr;
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_W'(RAS_DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   // Entry storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter. Each cycle picks the next fetch address from
// reset, redirect, stall hold, call target, return-address pop or increment,
// and keeps the return-address stack in step with calls and returns.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     PC_W      = 32,
   parameter int unsigned     STEP      = DEF_STEP,
   parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC),
   parameter int unsigned     RAS_DEPTH = 8,
   localparam int unsigned    CNT_W     = count_width(RAS_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [PC_W-1:0]  redirect_pc,
   input  logic             call,
   input  logic [PC_W-1:0]  call_target,
   input  logic             ret,
   output logic [PC_W-1:0]  pc,
   output logic [CNT_W-1:0] ras_count,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_overflow,
   output logic             ret_underflow
);

   pc_sel_e          w_sel;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  w_seq_pc;
   logic [PC_W-1:0]  w_next_pc;
   logic [PC_W-1:0]  w_ras_top;
   logic             w_push;
   logic             w_pop;
   logic             w_ras_empty;
   logic             w_ras_unf;
   logic             r_ret_underflow;

   // Sequential address; the carry out of the top bit is dropped so the PC wraps.
   assign w_seq_pc = r_pc + PC_W'(STEP);

   // Priority select: redirect overrides stall, stall masks call/ret, call beats ret.
   always_comb begin
      w_sel = SEL_SEQ;
      if (reset) begin
         w_sel = SEL_RESET;
      end else if (redirect_valid) begin
         w_sel = SEL_REDIRECT;
      end else if (stall) begin
         w_sel = SEL_HOLD;
      end else if (call) begin
         w_sel = SEL_CALL;
      end else if (ret) begin
         w_sel = SEL_RET;
      end
   end

   // Next-PC mux and stack commands derived from the selected source.
   always_comb begin
      w_next_pc = w_seq_pc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      case (w_sel)
         SEL_RESET:    w_next_pc = RESET_PC;
         SEL_REDIRECT: w_next_pc = redirect_pc;
         SEL_HOLD:     w_next_pc = r_pc;
         SEL_CALL: begin
            w_next_pc = call_target;
            w_push    = 1'b1;
         end
         SEL_RET: begin
            // A return with nothing to return to just falls through sequentially.
            w_next_pc = w_ras_empty ? w_seq_pc : w_ras_top;
            w_pop     = 1'b1;
         end
         default:      w_next_pc = w_seq_pc;
      endcase
   end

   // The return address pushed is the instruction after the current call. The
   // pushed entry is visible at the top on the very next cycle, so a ret right
   // after a call needs no extra forwarding.
   ras_stack #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (w_seq_pc),
      .i_pop       (w_pop),
      .o_top       (w_ras_top),
      .o_count     (ras_count),
      .o_full      (ras_full),
      .o_empty     (w_ras_empty),
      .o_overflow  (ras_overflow),
      .o_underflow (w_ras_unf)
   );

   // PC register; reset is folded into the select so it needs no separate branch.
   always_ff @(posedge clk) begin
      r_pc <= w_next_pc;
   end

   // One-cycle pulse when a return found the stack empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ret_underflow <= 1'b0;
      end else begin
         r_ret_underflow <= w_ras_unf;
      end
   end

   assign pc            = r_pc;
   assign ras_empty     = w_ras_empty;
   assign ret_underflow = r_ret_underflow;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances (32-bit/depth 4 and 8-bit/depth 2) share the
// same directed stimulus and are checked every cycle against a list-based model.
module tb_pc_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        call;
   logic [31:0] call_target;
   logic        ret;

   logic [31:0] pc_a;
   logic [2:0]  cnt_a;
   logic        emp_a, ful_a, ovf_a, unf_a;

   logic [7:0]  pc_b;
   logic [1:0]  cnt_b;
   logic        emp_b, ful_b, ovf_b, unf_b;

   int n_pass = 0;
   int n_tot  = 0;
   bit chk_en = 1'b0;

   pc_unit #(
      .PC_W(32), .STEP(1), .RESET_PC(32'h100), .RAS_DEPTH(4)
   ) dut_a (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .call(call), .call_target(call_target), .ret(ret),
      .pc(pc_a), .ras_count(cnt_a), .ras_empty(emp_a), .ras_full(ful_a),
      .ras_overflow(ovf_a), .ret_underflow(unf_a)
   );

   pc_unit #(
      .PC_W(8), .STEP(1), .RESET_PC(8'hFC), .RAS_DEPTH(2)
   ) dut_b (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[7:0]),
      .call(call), .call_target(call_target[7:0]), .ret(ret),
      .pc(pc_b), .ras_count(cnt_b), .ras_empty(emp_b), .ras_full(ful_b),
      .ras_overflow(ovf_b), .ret_underflow(unf_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   // The stack is an ordered list, oldest entry at index 0.
   int unsigned  m_depth [2] = '{4, 2};
   logic [31:0]  m_mask  [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
   logic [31:0]  m_rst   [2] = '{32'h100, 32'hFC};
   logic [31:0]  m_pc    [2];
   logic [31:0]  m_stk   [2][8];
   int           m_cnt   [2];
   bit           m_ovf   [2];
   bit           m_unf   [2];

   task automatic model_push(input int k, input logic [31:0] val);
      if (m_cnt[k] == int'(m_depth[k])) begin
         for (int i = 0; i < int'(m_depth[k]) - 1; i++) m_stk[k][i] = m_stk[k][i+1];
         m_stk[k][m_depth[k]-1] = val;
         m_ovf[k] = 1'b1;
      end else begin
         m_stk[k][m_cnt[k]] = val;
         m_cnt[k]++;
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [31:0] nxt;
         nxt = (m_pc[k] + 32'd1) & m_mask[k];
         m_unf[k] = 1'b0;
         if (reset) begin
            m_pc[k]  = m_rst[k];
            m_cnt[k] = 0;
            m_ovf[k] = 1'b0;
         end else if (redirect_valid) begin
            m_pc[k] = redirect_pc & m_mask[k];
         end else if (stall) begin
            m_pc[k] = m_pc[k];
         end else if (call) begin
            model_push(k, nxt);
            m_pc[k] = call_target & m_mask[k];
         end else if (ret) begin
            if (m_cnt[k] > 0) begin
               m_cnt[k]--;
               m_pc[k] = m_stk[k][m_cnt[k]];
            end else begin
               m_pc[k]  = nxt;
               m_unf[k] = 1'b1;
            end
         end else begin
            m_pc[k] = nxt;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
   endtask

   // Compare process: every output of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("a.pc",       pc_a,          m_pc[0]);
         chk("a.count",    32'(cnt_a),    32'(m_cnt[0]));
         chk("a.empty",    32'(emp_a),    32'(m_cnt[0] == 0));
         chk("a.full",     32'(ful_a),    32'(m_cnt[0] == 4));
         chk("a.overflow", 32'(ovf_a),    32'(m_ovf[0]));
         chk("a.underflow",32'(unf_a),    32'(m_unf[0]));
         chk("b.pc",       32'(pc_b),     m_pc[1]);
         chk("b.count",    32'(cnt_b),    32'(m_cnt[1]));
         chk("b.empty",    32'(emp_b),    32'(m_cnt[1] == 0));
         chk("b.full",     32'(ful_b),    32'(m_cnt[1] == 2));
         chk("b.overflow", 32'(ovf_b),    32'(m_ovf[1]));
         chk("b.underflow",32'(unf_b),    32'(m_unf[1]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic st, input logic cl, input logic [31:0] ct,
                       input logic rt);
      reset = r; redirect_valid = rv; redirect_pc = rpc;
      stall = st; call = cl; call_target = ct; ret = rt;
      @(negedge clk);
   endtask

   task automatic seq1();           step(0, 0, 0, 0, 0, 0, 0); endtask
   task automatic redir(input logic [31:0] a); step(0, 1, a, 0, 0, 0, 0); endtask
   task automatic do_call(input logic [31:0] t); step(0, 0, 0, 0, 1, t, 0); endtask
   task automatic do_ret();         step(0, 0, 0, 0, 0, 0, 1); endtask

   initial begin
      // Reset and free-running count, with an 8-bit wrap on instance b.
      step(1, 0, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      chk("lit.reset_pc", pc_a, 32'h100);
      chk("lit.reset_cnt", 32'(cnt_a), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         seq1();
         chk("lit.seq", pc_a, 32'h100 + 32'(i));
         if (i == 3) chk("lit.b_ff", 32'(pc_b), 32'hFF);
      end
      chk("lit.b_wrap", 32'(pc_b), 32'h00);

      // Call, three sequential cycles, return.
      redir(32'h10);
      do_call(32'h80);
      chk("lit.call_pc", pc_a, 32'h80);
      chk("lit.call_cnt", 32'(cnt_a), 32'd1);
      seq1(); seq1(); seq1();
      chk("lit.seq3", pc_a, 32'h83);
      do_ret();
      chk("lit.ret_pc", pc_a, 32'h11);
      chk("lit.ret_cnt", 32'(cnt_a), 32'd0);

      // Redirect wins over stall and call; stack untouched.
      do_call(32'h300);
      step(0, 1, 32'h200, 1, 1, 32'h999, 1);
      chk("lit.redir_pc", pc_a, 32'h200);
      chk("lit.redir_cnt", 32'(cnt_a), 32'd1);
      do_ret();
      chk("lit.ret2", pc_a, 32'h12);

      // Return immediately after a call.
      do_call(32'h50);
      do_ret();
      chk("lit.bypass", pc_a, 32'h13);

      // Stall with ret held for three cycles.
      redir(32'h3F);
      do_call(32'h40);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 1);
      chk("lit.stall_pc", pc_a, 32'h40);
      chk("lit.stall_cnt", 32'(cnt_a), 32'd1);
      seq1();
      chk("lit.unstall", pc_a, 32'h41);
      do_ret();
      chk("lit.ret3", pc_a, 32'h40);

      // Five nested calls overflow a depth-4 stack; five returns drain it.
      do_call(32'h1000); do_call(32'h2000); do_call(32'h3000);
      do_call(32'h4000); do_call(32'h5000);
      chk("lit.full", 32'(ful_a), 32'd1);
      chk("lit.ovf", 32'(ovf_a), 32'd1);
      chk("lit.cnt4", 32'(cnt_a), 32'd4);
      do_ret(); chk("lit.r1", pc_a, 32'h4001);
      do_ret(); chk("lit.r2", pc_a, 32'h3001);
      do_ret(); chk("lit.r3", pc_a, 32'h2001);
      do_ret(); chk("lit.r4", pc_a, 32'h1001);
      chk("lit.unf0", 32'(unf_a), 32'd0);
      do_ret();
      chk("lit.r5", pc_a, 32'h1002);
      chk("lit.unf1", 32'(unf_a), 32'd1);
      seq1();
      chk("lit.after", pc_a, 32'h1003);
      chk("lit.unf_clr", 32'(unf_a), 32'd0);

      // Call and ret together: call wins.
      step(0, 0, 0, 0, 1, 32'h600, 1);
      chk("lit.callret", pc_a, 32'h600);

      // Reset during a call: no push, counter restarts.
      step(1, 0, 0, 0, 1, 32'h777, 0);
      chk("lit.rst_pc", pc_a, 32'h100);
      chk("lit.rst_cnt", 32'(cnt_a), 32'd0);
      chk("lit.rst_ovf", 32'(ovf_a), 32'd0);
      seq1();
      chk("lit.rst_adv", pc_a, 32'h101);
      seq1();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
